// File: rtl/ring_demux_capture_4_pkg.sv
// Shared ring-counter constants and lane-select encodings for the 4-lane
// serial mux/demux pair (transmit and receive sides).
package ring_demux_capture_4_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [LANES-1:0] RING_IDLE  = 4'b0000;
  localparam logic [LANES-1:0] RING_FIRST = 4'b1000;
  localparam logic [LANES-1:0] RING_LAST  = 4'b0001;

  typedef enum logic [LANES-1:0] {
    IDLE  = 4'b0000,
    LANE3 = 4'b1000,
    LANE2 = 4'b0100,
    LANE1 = 4'b0010,
    LANE0 = 4'b0001
  } ring_state_e;

endpackage

// File: rtl/ring_demux_capture_4_ring_counter_4.sv
// One-hot 4-bit lane shifter: load arms lane 3, advance walks toward lane 0
// and then idle. Any multi-hot value falls back to idle on the next edge.
module ring_counter_4
  import ring_demux_capture_4_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  output logic [LANES-1:0] ring_o
);

  logic [LANES-1:0] ring_q;
  logic [LANES-1:0] ring_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q <= RING_IDLE;
    end else begin
      ring_q <= ring_d;
    end
  end

  always_comb begin
    ring_d = RING_IDLE;
    if (load_i) begin
      ring_d = RING_FIRST;
    end else begin
      case (ring_q)
        LANE3:   ring_d = advance_i ? LANE2 : LANE3;
        LANE2:   ring_d = advance_i ? LANE1 : LANE2;
        LANE1:   ring_d = advance_i ? LANE0 : LANE1;
        LANE0:   ring_d = advance_i ? IDLE  : LANE0;
        default: ring_d = RING_IDLE;
      endcase
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/ring_demux_capture_4.sv
// Receive-side demux: steers serial bits (lane 3 first) into a lane shadow
// under a one-hot ring, then publishes the full word with a valid pulse.
module ring_demux_capture_4
  import ring_demux_capture_4_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sync,
  input  logic       step,
  input  logic       data_in,
  output logic       bit_3,
  output logic       bit_2,
  output logic       bit_1,
  output logic       bit_0,
  output logic       valid,
  output logic       busy,
  output logic       abort,
  output logic [3:0] ring_counter
);

  logic [LANES-1:0] ring;
  logic [LANES-1:0] lane_we;
  logic [LANES-1:0] shadow_q, shadow_d;
  logic [LANES-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             complete;

  ring_counter_4 u_ring (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .load_i    (sync),
    .advance_i (step),
    .ring_o    (ring)
  );

  // One AND per lane; sync suppresses capture so the sync cycle never writes.
  assign lane_we  = {LANES{step & ~sync}} & ring;
  assign complete = step & ~sync & (ring == RING_LAST);

  always_comb begin
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = 1'b0;
    abort_d  = 1'b0;
    if (sync) begin
      shadow_d = '0;
      abort_d  = (ring != RING_IDLE);
    end else begin
      shadow_d = (lane_we & {LANES{data_in}}) | (~lane_we & shadow_q);
      if (complete) begin
        // Bit 0 bypasses the shadow so the word is ready on the same edge.
        word_d  = {shadow_q[3:1], data_in};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
    end
  end

  assign bit_3        = word_q[3];
  assign bit_2        = word_q[2];
  assign bit_1        = word_q[1];
  assign bit_0        = word_q[0];
  assign valid        = valid_q;
  assign abort        = abort_q;
  assign busy         = |ring;
  assign ring_counter = ring;

endmodule
